beam_coord_gen: RTL and testbench
=================================

Name: beam_coord_gen

Overview:
- Pixel-sequencing engine for the player's laser beam in the 160x120 VGA game.
- On a go request from the top-level draw sequencer, it captures the beam anchor (x, y) and colour.
- It then emits one vertical pixel per clock, with a write strobe, to the shared VGA plot mux, and pulses done when the beam has been fully emitted.
- It sits beside the per-sprite square generators in the datapath and shares their go/wren/done handshake.

Parameters:
- BEAM_LEN, 4, number of vertically stacked pixels in the beam (1..15).
- SCREEN_W, 160, horizontal resolution; pixels with x >= SCREEN_W are never written.
- SCREEN_H, 120, vertical resolution; pixels with y >= SCREEN_H are never written.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- beam_x  in  8  beam anchor column.
- beam_y  in  7  beam anchor row (top pixel of the beam).
- beam_c  in  3  beam colour (RGB, 1 bit per channel).
- go  in  1  draw request; held high by the sequencer until done is seen.
- wren  out  1  pixel write strobe; x/y/colour are valid when high.
- done  out  1  one-cycle completion pulse.
- x  out  8  pixel column.
- y  out  7  pixel row.
- colour  out  3  pixel colour.

Behaviour:
- Reset (async, any time including mid-draw):
  - State goes to IDLE; latched inputs, counter, x, y, colour, wren and done all go to 0.
  - Drawing resumes only on a fresh go after reset deasserts.
- FSM states: IDLE, LOAD, DRAW, DONE, WAIT. All outputs are registered.
- IDLE: wren=0, done=0. If go=1 at a rising edge, go to LOAD.
- LOAD (1 cycle):
  - Latch beam_x, beam_y, beam_c into internal registers.
  - Pixel counter i=0.
  - Input changes after this edge have no effect on the current draw.
- DRAW:
  - Each cycle presents pixel i: x=lx, y=ly+i, colour=lc.
  - Row arithmetic is computed at 8 bits so ly+i never wraps to row 0.
  - wren=1 only if lx < SCREEN_W and ly+i < SCREEN_H; otherwise wren=0 but the slot is still consumed.
  - i increments; after pixel BEAM_LEN-1, go to DONE.
  - Exactly BEAM_LEN DRAW cycles.
- DONE (1 cycle): wren=0, done=1; x/y/colour hold the last pixel. Next state is WAIT.
- WAIT:
  - done=0; go to IDLE when go=0.
  - If go remains high, stay in WAIT; no redraw.
- Latency: go sampled at edge k gives LOAD after k, pixel 0 after edge k+1, last pixel after edge k+BEAM_LEN, done high after edge k+BEAM_LEN+1.
- go dropping during LOAD/DRAW is ignored; the sequence always completes.
- wren is never high in IDLE, LOAD, DONE or WAIT.
- The sequencer advances on done, so go falls the cycle after done and the block returns to IDLE two cycles after done.

Test Plan:
- Basic beam: reset, then beam_x=50, beam_y=60, beam_c=3'b111, go=1.
  - Pixels (50,60),(50,61),(50,62),(50,63) on 4 consecutive cycles with wren=1 and colour=7.
  - Then done=1 for exactly 1 cycle; drop go and check return to IDLE.
- Input capture: change beam_x/beam_y/beam_c during DRAW.
  - All emitted pixels keep the LOAD-time values.
- Bottom clipping: beam_y=118, BEAM_LEN=4.
  - wren=1 for rows 118 and 119, wren=0 for the 120 and 121 slots.
  - done still arrives after 4 DRAW cycles.
- Right clipping: beam_x=160.
  - wren=0 on all 4 slots; done pulses once.
- go held high after done:
  - Block stays in WAIT with wren=0 and no redraw.
  - Releasing go for 1 cycle and reasserting it restarts a full draw.
- Async reset mid-DRAW (after 2 pixels):
  - wren, done, x, y and colour go to 0 immediately, without waiting for a clock edge.
  - After release with go=1, a complete new 4-pixel sequence is emitted.

Source files
------------

// File: rtl/beam_coord_gen.sv
// rtl/beam_coord_gen.sv - vertical laser-beam pixel sequencer with go/wren/done handshake
module beam_coord_gen #(
    parameter int BEAM_LEN = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] beam_x,
    input  logic [6:0] beam_y,
    input  logic [2:0] beam_c,
    input  logic       go,
    output logic       wren,
    output logic       done,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_DRAW = 3'd2,
        S_DONE = 3'd3,
        S_WAIT = 3'd4
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(BEAM_LEN - 1);
    localparam logic [8:0] X_LIMIT  = 9'(SCREEN_W);
    localparam logic [8:0] Y_LIMIT  = 9'(SCREEN_H);

    state_t     state_q, state_d;
    logic [7:0] lx_q, lx_d;
    logic [6:0] ly_q, ly_d;
    logic [2:0] lc_q, lc_d;
    logic [3:0] cnt_q, cnt_d;
    logic       wren_q, wren_d;
    logic       done_q, done_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic [7:0] row;

    // Row is carried at 8 bits so a beam running off the bottom is clipped, not wrapped to row 0.
    function automatic logic on_screen(input logic [7:0] px, input logic [7:0] py);
        return ({1'b0, px} < X_LIMIT) && ({1'b0, py} < Y_LIMIT);
    endfunction

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one LOAD, BEAM_LEN DRAW cycles, one DONE, then park until go falls.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go) state_d = S_LOAD;
            S_LOAD:  state_d = S_DRAW;
            S_DRAW:  if (cnt_q == LAST_IDX) state_d = S_DONE;
            S_DONE:  state_d = S_WAIT;
            S_WAIT:  if (!go) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values: the pixel to show after the coming edge.
    always_comb begin
        lx_d     = lx_q;
        ly_d     = ly_q;
        lc_d     = lc_q;
        cnt_d    = cnt_q;
        wren_d   = 1'b0;
        done_d   = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        row      = 8'd0;
        case (state_q)
            S_LOAD: begin
                lx_d     = beam_x;
                ly_d     = beam_y;
                lc_d     = beam_c;
                cnt_d    = 4'd0;
                row      = {1'b0, beam_y};
                x_d      = beam_x;
                y_d      = row[6:0];
                colour_d = beam_c;
                wren_d   = on_screen(beam_x, row);
            end
            S_DRAW: begin
                if (cnt_q != LAST_IDX) begin
                    cnt_d    = cnt_q + 4'd1;
                    row      = {1'b0, ly_q} + {4'd0, cnt_q} + 8'd1;
                    x_d      = lx_q;
                    y_d      = row[6:0];
                    colour_d = lc_q;
                    wren_d   = on_screen(lx_q, row);
                end else begin
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Latched beam parameters, pixel counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lx_q     <= 8'd0;
            ly_q     <= 7'd0;
            lc_q     <= 3'd0;
            cnt_q    <= 4'd0;
            wren_q   <= 1'b0;
            done_q   <= 1'b0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'd0;
        end else begin
            lx_q     <= lx_d;
            ly_q     <= ly_d;
            lc_q     <= lc_d;
            cnt_q    <= cnt_d;
            wren_q   <= wren_d;
            done_q   <= done_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
        end
    end

    assign wren   = wren_q;
    assign done   = done_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;

endmodule

// File: tb/tb_beam_coord_gen.sv
// tb/tb_beam_coord_gen.sv - self-checking bench for beam_coord_gen
module tb_beam_coord_gen;

    localparam int BEAM_LEN = 4;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    logic       clk;
    logic       reset;
    logic [7:0] beam_x;
    logic [6:0] beam_y;
    logic [2:0] beam_c;
    logic       go;
    logic       wren;
    logic       done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    int n_pass;
    int n_total;

    beam_coord_gen #(
        .BEAM_LEN(BEAM_LEN),
        .SCREEN_W(SCREEN_W),
        .SCREEN_H(SCREEN_H)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .beam_x (beam_x),
        .beam_y (beam_y),
        .beam_c (beam_c),
        .go     (go),
        .wren   (wren),
        .done   (done),
        .x      (x),
        .y      (y),
        .colour (colour)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input int bx, input int by, input int bc);
        beam_x = 8'(bx);
        beam_y = 7'(by);
        beam_c = 3'(bc);
        go     = 1'b1;
    endtask

    // Called at the negedge just before the edge that samples go in IDLE.
    task automatic check_seq(input int bx, input int by, input int bc, input bit mutate,
                             input bit drop_go, input int abort_after);
        int  row;
        bit  exp_w;
        @(negedge clk);
        n_total++;
        if (wren !== 1'b0 || done !== 1'b0)
            $display("FAIL load_quiet: wren=%0b done=%0b expected 0 0", wren, done);
        else
            n_pass++;
        for (int i = 0; i < BEAM_LEN; i++) begin
            @(negedge clk);
            row   = by + i;
            exp_w = (bx < SCREEN_W) && (row < SCREEN_H);
            n_total++;
            if (wren !== exp_w || x !== 8'(bx) || y !== 7'(row) || colour !== 3'(bc) || done !== 1'b0)
                $display("FAIL pixel%0d: got wren=%0b x=%0d y=%0d c=%0d done=%0b, expected wren=%0b x=%0d y=%0d c=%0d done=0",
                         i, wren, x, y, colour, done, exp_w, bx, 7'(row), bc);
            else
                n_pass++;
            if (mutate) begin
                beam_x = 8'($urandom);
                beam_y = 7'($urandom);
                beam_c = 3'($urandom);
            end
            if (abort_after == i + 1) return;
        end
        @(negedge clk);
        row = by + BEAM_LEN - 1;
        n_total++;
        if (done !== 1'b1 || wren !== 1'b0 || x !== 8'(bx) || y !== 7'(row) || colour !== 3'(bc))
            $display("FAIL done_pulse: got done=%0b wren=%0b x=%0d y=%0d c=%0d, expected done=1 wren=0 x=%0d y=%0d c=%0d",
                     done, wren, x, y, colour, bx, 7'(row), bc);
        else
            n_pass++;
        if (!drop_go) return;
        go = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            n_total++;
            if (done !== 1'b0 || wren !== 1'b0)
                $display("FAIL after_done%0d: done=%0b wren=%0b expected 0 0", j, done, wren);
            else
                n_pass++;
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        go     = 1'b0;
        beam_x = 8'd0;
        beam_y = 7'd0;
        beam_c = 3'd0;
        @(negedge clk);
        n_total++;
        if (wren !== 1'b0 || done !== 1'b0 || x !== 8'd0 || y !== 7'd0 || colour !== 3'd0)
            $display("FAIL reset_state: wren=%0b done=%0b x=%0d y=%0d c=%0d expected all 0",
                     wren, done, x, y, colour);
        else
            n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if (wren !== 1'b0 || done !== 1'b0)
            $display("FAIL idle_quiet: wren=%0b done=%0b expected 0 0", wren, done);
        else
            n_pass++;
    endtask

    task automatic test_basic();
        @(negedge clk);
        drive(50, 60, 7);
        check_seq(50, 60, 7, 1'b0, 1'b1, -1);
    endtask

    task automatic test_capture();
        @(negedge clk);
        drive(12, 33, 5);
        check_seq(12, 33, 5, 1'b1, 1'b1, -1);
    endtask

    task automatic test_bottom_clip();
        @(negedge clk);
        drive(80, 118, 2);
        check_seq(80, 118, 2, 1'b0, 1'b1, -1);
        @(negedge clk);
        drive(3, 127, 6);
        check_seq(3, 127, 6, 1'b0, 1'b1, -1);
    endtask

    task automatic test_right_clip();
        @(negedge clk);
        drive(160, 10, 4);
        check_seq(160, 10, 4, 1'b0, 1'b1, -1);
        @(negedge clk);
        drive(159, 0, 1);
        check_seq(159, 0, 1, 1'b0, 1'b1, -1);
    endtask

    task automatic test_go_held();
        @(negedge clk);
        drive(20, 40, 3);
        check_seq(20, 40, 3, 1'b0, 1'b0, -1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_total++;
            if (wren !== 1'b0 || done !== 1'b0)
                $display("FAIL wait_held%0d: wren=%0b done=%0b expected 0 0", k, wren, done);
            else
                n_pass++;
        end
        go = 1'b0;
        @(negedge clk);
        drive(21, 41, 6);
        check_seq(21, 41, 6, 1'b0, 1'b1, -1);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(70, 30, 5);
        check_seq(70, 30, 5, 1'b0, 1'b1, 2);
        #2;
        reset = 1'b1;
        #1;
        n_total++;
        if (wren !== 1'b0 || done !== 1'b0 || x !== 8'd0 || y !== 7'd0 || colour !== 3'd0)
            $display("FAIL async_reset: wren=%0b done=%0b x=%0d y=%0d c=%0d expected all 0",
                     wren, done, x, y, colour);
        else
            n_pass++;
        @(negedge clk);
        drive(90, 100, 1);
        reset = 1'b0;
        check_seq(90, 100, 1, 1'b0, 1'b1, -1);
    endtask

    task automatic test_random();
        int bx, by, bc;
        bit mut;
        for (int r = 0; r < 10; r++) begin
            bx  = int'($urandom_range(0, 175));
            by  = int'($urandom_range(0, 127));
            bc  = int'($urandom_range(0, 7));
            mut = 1'($urandom);
            @(negedge clk);
            drive(bx, by, bc);
            check_seq(bx, by, bc, mut, 1'b1, -1);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(0, 116, 7);
        check_seq(0, 116, 7, 1'b0, 1'b1, -1);
        drive(1, 0, 2);
        check_seq(1, 0, 2, 1'b0, 1'b1, -1);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_basic();
        test_capture();
        test_bottom_clip();
        test_right_clip();
        test_go_held();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
